// File: rtl/bsg_cache_pkg.sv
// Shared types and helpers for the cache store buffer: entry layout, occupancy states and entry width.
package bsg_cache_pkg;

  localparam int sbuf_addr_width_lp = 32;
  localparam int sbuf_data_width_lp = 64;
  localparam int sbuf_ways_lp       = 8;

  typedef struct packed {
    logic [sbuf_addr_width_lp-1:0]   addr;
    logic [sbuf_data_width_lp-1:0]   data;
    logic [sbuf_data_width_lp/8-1:0] mask;
    logic [$clog2(sbuf_ways_lp)-1:0] way_id;
  } bsg_cache_sbuf_entry_s;

  typedef enum logic [1:0] {
    e_sbuf_empty = 2'd0,
    e_sbuf_one   = 2'd1,
    e_sbuf_two   = 2'd2
  } sbuf_state_e;

  function automatic int sbuf_entry_width(int addr_width, int data_width, int ways);
    return addr_width + data_width + data_width/8 + ((ways > 1) ? $clog2(ways) : 1);
  endfunction

endpackage

// File: rtl/bsg_cache_sbuf_queue.sv
// Two-register store-buffer datapath: el1 is the head, el0 the newer entry; data_o can bypass straight from data_i.
module bsg_cache_sbuf_queue #(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic [width_p-1:0] data_i,
  input  logic               el0_en_i,
  input  logic               el1_en_i,
  input  logic               mux0_sel_i,
  input  logic               mux1_sel_i,
  output logic [width_p-1:0] data_o,
  output logic [width_p-1:0] el0_snoop_o,
  output logic [width_p-1:0] el1_snoop_o
);

  logic [width_p-1:0] el0_q, el1_q, el1_d;

  assign el1_d = mux1_sel_i ? el0_q : data_i;

  // NOTE: entry storage carries no reset; occupancy in the controller decides which entries are meaningful.
  always_ff @(posedge clk_i) begin
    if (el0_en_i) el0_q <= data_i;
    if (el1_en_i) el1_q <= el1_d;
  end

  assign data_o      = mux0_sel_i ? el1_q : data_i;
  assign el0_snoop_o = el0_q;
  assign el1_snoop_o = el1_q;

endmodule

// File: rtl/bsg_cache_sbuf_ctrl.sv
// Two-entry store buffer controller with pass-through when empty and byte-merged load bypass.
// Bypass compare/merge logic is present only when BSG_CACHE_SBUF_BYPASS_EN is defined.
module bsg_cache_sbuf_ctrl
  import bsg_cache_pkg::*;
#(
  parameter int data_width_p = 64,
  parameter int addr_width_p = 32,
  parameter int ways_p       = 8,
  localparam int mask_width_lp = data_width_p/8,
  localparam int lg_ways_lp    = (ways_p > 1) ? $clog2(ways_p) : 1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     v_i,
  output logic                     ready_o,
  input  logic [addr_width_p-1:0]  addr_i,
  input  logic [data_width_p-1:0]  data_i,
  input  logic [mask_width_lp-1:0] mask_i,
  input  logic [lg_ways_lp-1:0]    way_i,
  output logic                     v_o,
  input  logic                     yumi_i,
  output logic [addr_width_p-1:0]  addr_o,
  output logic [data_width_p-1:0]  data_o,
  output logic [mask_width_lp-1:0] mask_o,
  output logic [lg_ways_lp-1:0]    way_o,
  input  logic                     bypass_v_i,
  input  logic [addr_width_p-1:0]  bypass_addr_i,
  output logic [data_width_p-1:0]  bypass_data_o,
  output logic [mask_width_lp-1:0] bypass_mask_o,
  output logic                     empty_o
);

  localparam int byte_offset_lp  = $clog2(mask_width_lp);
  localparam int entry_width_lp  = sbuf_entry_width(addr_width_p, data_width_p, ways_p);

  typedef struct packed {
    logic [addr_width_p-1:0]  addr;
    logic [data_width_p-1:0]  data;
    logic [mask_width_lp-1:0] mask;
    logic [lg_ways_lp-1:0]    way_id;
  } entry_s;

  sbuf_state_e num_els_q, num_els_d;
  logic        el0_en, el1_en, mux0_sel, mux1_sel;
  entry_s      in_entry, head_entry, el0_entry, el1_entry;

  assign in_entry = '{addr: addr_i, data: data_i, mask: mask_i, way_id: way_i};

  bsg_cache_sbuf_queue #(.width_p(entry_width_lp)) queue (
    .clk_i      (clk_i),
    .data_i     (in_entry),
    .el0_en_i   (el0_en),
    .el1_en_i   (el1_en),
    .mux0_sel_i (mux0_sel),
    .mux1_sel_i (mux1_sel),
    .data_o     (head_entry),
    .el0_snoop_o(el0_entry),
    .el1_snoop_o(el1_entry)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) num_els_q <= e_sbuf_empty;
    else         num_els_q <= num_els_d;
  end

  // NOTE: every combinational output gets a default first so no path through the case can infer a latch.
  always_comb begin
    num_els_d = num_els_q;
    case (num_els_q)
      e_sbuf_empty: if (v_i & ~yumi_i) num_els_d = e_sbuf_one;
      e_sbuf_one: begin
        if (v_i & ~yumi_i)      num_els_d = e_sbuf_two;
        else if (~v_i & yumi_i) num_els_d = e_sbuf_empty;
      end
      e_sbuf_two:   if (yumi_i) num_els_d = e_sbuf_one;
      default:      num_els_d = e_sbuf_empty;
    endcase
  end

  // Full buffer refuses input regardless of yumi_i, keeping ready_o free of any yumi_i path.
  always_comb begin
    ready_o  = 1'b0;
    v_o      = 1'b0;
    el0_en   = 1'b0;
    el1_en   = 1'b0;
    mux0_sel = 1'b0;
    mux1_sel = 1'b0;
    case (num_els_q)
      e_sbuf_empty: begin
        ready_o = 1'b1;
        v_o     = v_i;
        el1_en  = v_i & ~yumi_i;
      end
      e_sbuf_one: begin
        ready_o  = 1'b1;
        v_o      = 1'b1;
        mux0_sel = 1'b1;
        el1_en   = v_i & yumi_i;
        el0_en   = v_i & ~yumi_i;
      end
      e_sbuf_two: begin
        v_o      = 1'b1;
        mux0_sel = 1'b1;
        mux1_sel = 1'b1;
        el1_en   = yumi_i;
      end
      default: ;
    endcase
    if (reset_i) begin
      ready_o = 1'b0;
      v_o     = 1'b0;
    end
  end

  assign addr_o  = head_entry.addr;
  assign data_o  = head_entry.data;
  assign mask_o  = head_entry.mask;
  assign way_o   = head_entry.way_id;
  assign empty_o = reset_i | (num_els_q == e_sbuf_empty);

`ifdef BSG_CACHE_SBUF_BYPASS_EN
  logic el0_hit, el1_hit;
  logic unused_fields;

  assign el0_hit = (num_els_q == e_sbuf_two)
                 & (el0_entry.addr[addr_width_p-1:byte_offset_lp] == bypass_addr_i[addr_width_p-1:byte_offset_lp]);
  assign el1_hit = (num_els_q != e_sbuf_empty)
                 & (el1_entry.addr[addr_width_p-1:byte_offset_lp] == bypass_addr_i[addr_width_p-1:byte_offset_lp]);
  assign unused_fields = ^{el0_entry, el1_entry};

  // Per byte the newer entry (el0) wins over the head.
  always_comb begin
    bypass_data_o = '0;
    bypass_mask_o = '0;
    if (bypass_v_i & ~reset_i) begin
      for (int b = 0; b < mask_width_lp; b++) begin
        if (el0_hit & el0_entry.mask[b]) begin
          bypass_data_o[8*b+:8] = el0_entry.data[8*b+:8];
          bypass_mask_o[b]      = 1'b1;
        end else if (el1_hit & el1_entry.mask[b]) begin
          bypass_data_o[8*b+:8] = el1_entry.data[8*b+:8];
          bypass_mask_o[b]      = 1'b1;
        end
      end
    end
  end
`else
  logic unused_bypass;
  assign unused_bypass = ^{bypass_v_i, bypass_addr_i, el0_entry, el1_entry};
  assign bypass_data_o = '0;
  assign bypass_mask_o = '0;
`endif

`ifndef SYNTHESIS
  yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o)
    else $error("yumi_i asserted while v_o is low");
`endif

endmodule

// File: tb/tb_bsg_cache_sbuf_ctrl.sv
// Directed self-checking bench for bsg_cache_sbuf_ctrl; bypass expectations follow BSG_CACHE_SBUF_BYPASS_EN.
module tb_bsg_cache_sbuf_ctrl;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        v_i, ready_o, v_o, yumi_i, bypass_v_i, empty_o;
  logic [31:0] addr_i, addr_o, bypass_addr_i;
  logic [63:0] data_i, data_o, bypass_data_o;
  logic [7:0]  mask_i, mask_o, bypass_mask_o;
  logic [2:0]  way_i, way_o;

  int vectors = 0;
  int errors  = 0;

  always #5 clk_i = ~clk_i;

  bsg_cache_sbuf_ctrl #(.data_width_p(64), .addr_width_p(32), .ways_p(8)) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .v_i          (v_i),
    .ready_o      (ready_o),
    .addr_i       (addr_i),
    .data_i       (data_i),
    .mask_i       (mask_i),
    .way_i        (way_i),
    .v_o          (v_o),
    .yumi_i       (yumi_i),
    .addr_o       (addr_o),
    .data_o       (data_o),
    .mask_o       (mask_o),
    .way_o        (way_o),
    .bypass_v_i   (bypass_v_i),
    .bypass_addr_i(bypass_addr_i),
    .bypass_data_o(bypass_data_o),
    .bypass_mask_o(bypass_mask_o),
    .empty_o      (empty_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [63:0] d,
                       input logic [7:0] m, input logic [2:0] w, input logic y);
    v_i = v; addr_i = a; data_i = d; mask_i = m; way_i = w; yumi_i = y;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset_i = 1'b1; bypass_v_i = 1'b1; bypass_addr_i = '0;
    drive(1'b1, 32'h0, 64'h0, 8'hFF, 3'd0, 1'b0);
    tick();
    #1;
    check("reset_ready", 64'(ready_o), 64'(1'b0));
    check("reset_v_o", 64'(v_o), 64'(1'b0));
    check("reset_empty", 64'(empty_o), 64'(1'b1));
    check("reset_bypass_mask", 64'(bypass_mask_o), 64'h0);
    tick();
    reset_i = 1'b0; bypass_v_i = 1'b0;
    drive(1'b0, 32'h0, 64'h0, 8'h0, 3'd0, 1'b0);
    #1;
    check("idle_ready", 64'(ready_o), 64'(1'b1));
    check("idle_v_o", 64'(v_o), 64'(1'b0));

    // Pass-through: empty buffer, store consumed in the same cycle
    drive(1'b1, 32'h100, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, 3'd3, 1'b1);
    #1;
    check("pt_v_o", 64'(v_o), 64'(1'b1));
    check("pt_data", data_o, 64'hAAAA_AAAA_AAAA_AAAA);
    check("pt_addr", 64'(addr_o), 64'h100);
    check("pt_way", 64'(way_o), 64'd3);
    check("pt_empty", 64'(empty_o), 64'(1'b1));
    tick();
    drive(1'b0, 32'h0, 64'h0, 8'h0, 3'd0, 1'b0);
    #1;
    check("pt_after_empty", 64'(empty_o), 64'(1'b1));
    check("pt_after_v_o", 64'(v_o), 64'(1'b0));

    // Fill to two, third store refused, drain in order
    drive(1'b1, 32'h10, 64'hA, 8'h01, 3'd1, 1'b0);
    #1;
    check("fill_a_ready", 64'(ready_o), 64'(1'b1));
    tick();
    drive(1'b1, 32'h20, 64'hB, 8'h02, 3'd2, 1'b0);
    #1;
    check("fill_b_ready", 64'(ready_o), 64'(1'b1));
    check("fill_b_head", data_o, 64'hA);
    check("fill_b_empty", 64'(empty_o), 64'(1'b0));
    tick();
    drive(1'b1, 32'h30, 64'hC, 8'h04, 3'd4, 1'b0);
    #1;
    check("fill_c_ready", 64'(ready_o), 64'(1'b0));
    check("fill_c_head", data_o, 64'hA);
    tick();
    drive(1'b0, 32'h0, 64'h0, 8'h0, 3'd0, 1'b1);
    #1;
    check("drain_a_data", data_o, 64'hA);
    check("drain_a_addr", 64'(addr_o), 64'h10);
    check("drain_a_mask", 64'(mask_o), 64'h01);
    tick();
    #1;
    check("drain_b_v_o", 64'(v_o), 64'(1'b1));
    check("drain_b_data", data_o, 64'hB);
    check("drain_b_way", 64'(way_o), 64'd2);
    tick();
    drive(1'b0, 32'h0, 64'h0, 8'h0, 3'd0, 1'b0);
    #1;
    check("drain_empty", 64'(empty_o), 64'(1'b1));
    check("drain_v_o", 64'(v_o), 64'(1'b0));

    // Steady state at one entry: output stream lags input by one store
    drive(1'b1, 32'h40, 64'h100, 8'hFF, 3'd0, 1'b0);
    tick();
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 32'h40, 64'(32'h100 + i), 8'hFF, 3'd0, 1'b1);
      #1;
      check("stream_v_o", 64'(v_o), 64'(1'b1));
      check("stream_data", data_o, 64'(32'h100 + i - 1));
      tick();
    end
    drive(1'b0, 32'h0, 64'h0, 8'h0, 3'd0, 1'b1);
    #1;
    check("stream_last", data_o, 64'h10A);
    tick();
    drive(1'b0, 32'h0, 64'h0, 8'h0, 3'd0, 1'b0);
    #1;
    check("stream_empty", 64'(empty_o), 64'(1'b1));

    // Byte-merged bypass from two entries in the same word
    drive(1'b1, 32'h200, 64'h1111_1111_1111_1111, 8'h0F, 3'd0, 1'b0);
    tick();
    drive(1'b1, 32'h204, 64'h2222_2222_2222_2222, 8'h03, 3'd1, 1'b0);
    tick();
    drive(1'b0, 32'h0, 64'h0, 8'h0, 3'd0, 1'b0);
    bypass_v_i = 1'b1; bypass_addr_i = 32'h200;
    #1;
`ifdef BSG_CACHE_SBUF_BYPASS_EN
    check("byp_merge_mask", 64'(bypass_mask_o), 64'h0F);
    check("byp_merge_data", bypass_data_o, 64'h0000_0000_1111_2222);
`else
    check("byp_merge_mask", 64'(bypass_mask_o), 64'h0);
    check("byp_merge_data", bypass_data_o, 64'h0);
`endif
    bypass_addr_i = 32'h207;
    #1;
`ifdef BSG_CACHE_SBUF_BYPASS_EN
    check("byp_word_mask", 64'(bypass_mask_o), 64'h0F);
`else
    check("byp_word_mask", 64'(bypass_mask_o), 64'h0);
`endif
    bypass_addr_i = 32'h300;
    #1;
    check("byp_miss_mask", 64'(bypass_mask_o), 64'h0);
    check("byp_miss_data", bypass_data_o, 64'h0);
    bypass_v_i = 1'b0; bypass_addr_i = 32'h200;
    #1;
    check("byp_off_mask", 64'(bypass_mask_o), 64'h0);

    // Reset while full
    reset_i = 1'b1;
    #1;
    check("rst_full_ready", 64'(ready_o), 64'(1'b0));
    tick();
    reset_i = 1'b0;
    #1;
    check("rst_full_v_o", 64'(v_o), 64'(1'b0));
    check("rst_full_empty", 64'(empty_o), 64'(1'b1));
    check("rst_full_ready_after", 64'(ready_o), 64'(1'b1));

    // Pass-through store is not visible to bypass
    drive(1'b1, 32'h300, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 3'd5, 1'b1);
    bypass_v_i = 1'b1; bypass_addr_i = 32'h300;
    #1;
    check("byp_pt_mask", 64'(bypass_mask_o), 64'h0);
    tick();

    // Single head entry supplies upper bytes; stale contents ignored once drained
    drive(1'b1, 32'h400, 64'h3333_3333_3333_3333, 8'hF0, 3'd6, 1'b0);
    bypass_v_i = 1'b0;
    tick();
    drive(1'b0, 32'h0, 64'h0, 8'h0, 3'd0, 1'b0);
    bypass_v_i = 1'b1; bypass_addr_i = 32'h400;
    #1;
`ifdef BSG_CACHE_SBUF_BYPASS_EN
    check("byp_el1_mask", 64'(bypass_mask_o), 64'hF0);
    check("byp_el1_data", bypass_data_o, 64'h3333_3333_0000_0000);
`else
    check("byp_el1_mask", 64'(bypass_mask_o), 64'h0);
    check("byp_el1_data", bypass_data_o, 64'h0);
`endif
    yumi_i = 1'b1;
    tick();
    yumi_i = 1'b0;
    #1;
    check("byp_stale_mask", 64'(bypass_mask_o), 64'h0);
    check("byp_stale_empty", 64'(empty_o), 64'(1'b1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
